packet_sink: RTL and testbench
==============================

Name: packet_sink

Overview:
- Packet receiver for the NoC local port; the receiving end of the traffic the generator IP injects through `switch`.
- Attaches to a switch local (IP) port in place of, or beside, a generator node.
- Accepts flits with the codebase's ready/ready handshake and buffers them in a small FIFO.
- Drains the FIFO at a programmable rate to create backpressure, reassembles packets, checks destination and length, and exposes counters to the bench.

Parameters:
DATA_SIZE, 8, payload field width
ADDR_SIZE, 4, destination address field width
ADDR, 0, this node's address; compared against every flit
MEM_LOG2, 2, log2 of FIFO depth (depth = 2**MEM_LOG2)
DRAIN_PERIOD, 1, cycles per FIFO pop (>=1); larger values throttle the switch
MAX_PACK_LEN, 8, maximum legal flits per packet
CNT_W, 16, width of status counters

Ports:
clk  in  1  clock, rising edge
a_rst  in  1  asynchronous reset, active-low
data_i  in  DATA_SIZE+ADDR_SIZE+1  flit {last, dest_addr, data}; MSB = last flag
wr_ready_in  in  1  sender has a valid flit on data_i
r_ready_out  out  1  sink can accept a flit this cycle
pack_cnt  out  CNT_W  packets fully received (tail popped)
flit_cnt  out  CNT_W  flits popped
err_addr_cnt  out  CNT_W  packets containing at least one flit with dest_addr != ADDR
err_len_cnt  out  CNT_W  packets longer than MAX_PACK_LEN flits
last_len  out  8  length of the most recently completed packet
busy  out  1  FIFO non-empty or FSM in BODY

Behaviour:
Reset (a_rst low, asynchronous):
- Every output is 0, including r_ready_out.
- FIFO empty, FSM in HEAD, all internal counters 0.
- Reset asserted mid-packet discards buffered flits and the partial packet; no counter records it.

Accept handshake:
- A flit transfers at a posedge where wr_ready_in and r_ready_out are both 1.
- data_i is sampled only on that edge. wr_ready_in without r_ready_out is a stall; nothing is captured.
- r_ready_out is registered: next value = (next FIFO occupancy < 2**MEM_LOG2).
- First posedge after reset release sets r_ready_out to 1.
- When full, r_ready_out is 0 from the edge that filled the FIFO. It returns to 1 the edge after the pop that frees a slot.

FIFO:
- Depth 2**MEM_LOG2, pointers wrap modulo depth, occupancy counter MEM_LOG2+1 bits.
- Simultaneous push and pop in one edge leaves occupancy unchanged.

Drain:
- drain_cnt is held at 0 while the FIFO is empty and increments each cycle while it is non-empty.
- Pop when FIFO is non-empty and drain_cnt == DRAIN_PERIOD-1; drain_cnt returns to 0 on pop.
- With DRAIN_PERIOD=1: a flit accepted at edge N pops at edge N+1; counters update at that edge.

FSM (advances only on pop):
- HEAD: on pop, len=1 and bad_addr=(dest_addr!=ADDR).
  - last=1: complete the packet, stay in HEAD.
  - last=0: go to BODY.
- BODY: on pop, len=len+1 (saturating at 255) and bad_addr |= mismatch.
  - last=1: complete the packet, go to HEAD.

Packet completion, all in the pop edge:
- pack_cnt+1.
- last_len=len.
- err_addr_cnt+1 if bad_addr.
- err_len_cnt+1 if len > MAX_PACK_LEN.

Counters:
- flit_cnt increments on every pop.
- All CNT_W counters saturate at all-ones and do not wrap.

busy:
- Registered.
- Equals (next occupancy != 0) || (next state == BODY).

Optional Feature:
Macro PACKET_SINK_SEQ_CHECK_EN:
- Defined:
  - Adds output err_seq_cnt [CNT_W].
  - In BODY, each popped flit's data must equal previous data + 1 mod 2**DATA_SIZE.
  - A packet with any violation increments err_seq_cnt once at completion.
  - err_seq_cnt resets to 0 and saturates.
- Undefined: port absent, no sequence logic.

Test Plan:
1. Reset, then wr_ready_in=1 with one flit {last=1, addr=ADDR, data=8'h5A}, DRAIN_PERIOD=1 -> accepted on first edge with r_ready_out=1. One edge later: pack_cnt=1, flit_cnt=1, last_len=1, error counters 0, busy=0.
2. Packet of 4 flits (data 1,2,3,4; last on 4th), back-to-back -> pack_cnt=1, flit_cnt=4, last_len=4. Sequence errors 0 with PACKET_SINK_SEQ_CHECK_EN.
3. DRAIN_PERIOD=4, MEM_LOG2=2, 8-flit packet driven continuously -> r_ready_out falls after 4th acceptance. Thereafter one acceptance per 4 cycles. Final flit_cnt=8, pack_cnt=1, r_ready_out=1 at end.
4. 3-flit packet with 2nd flit addr=ADDR+1, then 10-flit packet with MAX_PACK_LEN=8 -> err_addr_cnt=1, err_len_cnt=1, pack_cnt=2, last_len=10.
5. Pull a_rst low after 2 flits of a 5-flit packet with FIFO holding 2 -> immediately all outputs 0. After release, a fresh 2-flit packet gives pack_cnt=1, flit_cnt=2.
6. CNT_W=4, send 17 single-flit packets -> pack_cnt saturates at 4'hF.

Source files
------------

// File: rtl/packet_sink.sv
// packet_sink: receiving end of NoC traffic on a switch local (IP) port.
//
// It accepts flits with the ready/ready handshake and stores them in a small
// FIFO. The FIFO is popped at a programmable rate, which lets the sink apply
// backpressure to the switch. Popped flits are reassembled into packets. Each
// packet is checked for destination address and length, and the results are
// kept in saturating status counters.
//
// Ports:
//   clk          in   rising-edge clock
//   a_rst        in   asynchronous reset, active-low
//   data_i       in   flit {last, dest_addr, data}; MSB is the last flag
//   wr_ready_in  in   sender presents a valid flit on data_i
//   r_ready_out  out  sink can accept a flit this cycle (registered)
//   pack_cnt     out  packets whose tail has been popped
//   flit_cnt     out  flits popped
//   err_addr_cnt out  packets with at least one flit whose dest_addr != ADDR
//   err_len_cnt  out  packets longer than MAX_PACK_LEN flits
//   last_len     out  length of the most recently completed packet
//   busy         out  FIFO non-empty or reassembly in progress (registered)
//   err_seq_cnt  out  packets whose body data is not an incrementing sequence
//                     (present only with PACKET_SINK_SEQ_CHECK_EN)
//
// Build option: define PACKET_SINK_SEQ_CHECK_EN to add the data-sequence
// checker and its err_seq_cnt port.
//
// Reassembly FSM
//   state | meaning
//   HEAD  | waiting for the first flit of a packet
//   BODY  | head popped, collecting flits until the one with last set

module packet_sink #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 4,
  parameter int ADDR         = 0,
  parameter int MEM_LOG2     = 2,
  parameter int DRAIN_PERIOD = 1,
  parameter int MAX_PACK_LEN = 8,
  parameter int CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           a_rst,
  input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
  input  logic                           wr_ready_in,
  output logic                           r_ready_out,
  output logic [CNT_W-1:0]               pack_cnt,
  output logic [CNT_W-1:0]               flit_cnt,
  output logic [CNT_W-1:0]               err_addr_cnt,
  output logic [CNT_W-1:0]               err_len_cnt,
  output logic [7:0]                     last_len,
  output logic                           busy
`ifdef PACKET_SINK_SEQ_CHECK_EN
  ,
  output logic [CNT_W-1:0]               err_seq_cnt
`endif
);

  localparam int FW    = DATA_SIZE + ADDR_SIZE + 1;
  localparam int DEPTH = 1 << MEM_LOG2;
  localparam int DCW   = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam logic [MEM_LOG2:0] FULL      = (MEM_LOG2+1)'(DEPTH);
  localparam logic [DCW-1:0]    DRAIN_TC  = DCW'(DRAIN_PERIOD - 1);
  localparam logic [ADDR_SIZE-1:0] MY_ADDR = ADDR_SIZE'(ADDR);

  typedef enum logic {HEAD, BODY} state_t;

  logic [FW-1:0]         mem [DEPTH];
  logic [MEM_LOG2-1:0]   wr_ptr;
  logic [MEM_LOG2-1:0]   rd_ptr;
  logic [MEM_LOG2:0]     occ;
  logic [MEM_LOG2:0]     occ_next;
  logic [DCW-1:0]        drain_cnt;
  state_t                state;
  logic [7:0]            len;
  logic                  bad_addr;

  logic                  push;
  logic                  pop;
  logic [FW-1:0]         head_flit;
  logic                  flit_last;
  logic [ADDR_SIZE-1:0]  flit_addr;
  logic [7:0]            len_new;
  logic                  bad_new;
  logic                  body_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign push      = wr_ready_in && r_ready_out;
  assign pop       = (occ != '0) && (drain_cnt == DRAIN_TC);
  assign head_flit = mem[rd_ptr];
  assign flit_last = head_flit[FW-1];
  assign flit_addr = head_flit[DATA_SIZE +: ADDR_SIZE];

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // Length and address status including the flit being popped this cycle,
  // so a tail flit completes the packet with its own contribution counted.
  always_comb begin
    len_new = 8'd1;
    bad_new = (flit_addr != MY_ADDR);
    if (state == BODY) begin
      len_new = (len == 8'hFF) ? len : len + 8'd1;
      bad_new = bad_new || bad_addr;
    end
  end

  assign body_next = pop ? !flit_last : (state == BODY);

`ifdef PACKET_SINK_SEQ_CHECK_EN
  logic [DATA_SIZE-1:0] flit_data;
  logic [DATA_SIZE-1:0] prev_data;
  logic                 seq_bad;
  logic                 seq_new;

  assign flit_data = head_flit[DATA_SIZE-1:0];
  // The head flit starts a fresh sequence; only body flits are compared.
  assign seq_new   = (state == BODY) &&
                     (seq_bad || (flit_data != (prev_data + 1'b1)));

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      prev_data   <= '0;
      seq_bad     <= 1'b0;
      err_seq_cnt <= '0;
    end else if (pop) begin
      prev_data <= flit_data;
      seq_bad   <= seq_new;
      if (flit_last && seq_new)
        err_seq_cnt <= sat_inc(err_seq_cnt);
    end
  end
`else
  // Payload bits are carried through the FIFO but only the sequence checker
  // looks at them.
  logic unused_data;
  assign unused_data = ^head_flit[DATA_SIZE-1:0];
`endif

  // Storage is not reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      drain_cnt    <= '0;
      r_ready_out  <= 1'b0;
      busy         <= 1'b0;
      state        <= HEAD;
      len          <= '0;
      bad_addr     <= 1'b0;
      pack_cnt     <= '0;
      flit_cnt     <= '0;
      err_addr_cnt <= '0;
      err_len_cnt  <= '0;
      last_len     <= '0;
    end else begin
      occ         <= occ_next;
      r_ready_out <= (occ_next < FULL);
      busy        <= (occ_next != '0) || body_next;

      if (push)
        wr_ptr <= wr_ptr + 1'b1;

      // The drain timer only runs while there is something to drain.
      if (occ == '0 || pop)
        drain_cnt <= '0;
      else
        drain_cnt <= drain_cnt + 1'b1;

      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        flit_cnt <= sat_inc(flit_cnt);
        len      <= len_new;
        bad_addr <= bad_new;

        case (state)
          HEAD: state <= flit_last ? HEAD : BODY;
          BODY: state <= flit_last ? HEAD : BODY;
          default: state <= HEAD;
        endcase

        if (flit_last) begin
          pack_cnt <= sat_inc(pack_cnt);
          last_len <= len_new;
          if (bad_new)
            err_addr_cnt <= sat_inc(err_addr_cnt);
          if (int'(len_new) > MAX_PACK_LEN)
            err_len_cnt <= sat_inc(err_len_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_sink.sv
// Testbench for packet_sink.
// Three instances share clock, reset and the input flit bus:
//   u_a  default parameters
//   u_b  DRAIN_PERIOD = 4 (backpressure and mid-packet reset)
//   u_c  CNT_W = 4 (counter saturation)
// Each scenario resets all instances and then inspects only its own instance.

module tb_packet_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] din;
  logic        wr;

  logic        rdy_a, busy_a, rdy_b, busy_b, rdy_c, busy_c;
  logic [15:0] pack_a, flit_a, eaddr_a, elen_a;
  logic [15:0] pack_b, flit_b, eaddr_b, elen_b;
  logic [3:0]  pack_c, flit_c, eaddr_c, elen_c;
  logic [7:0]  llen_a, llen_b, llen_c;
`ifdef PACKET_SINK_SEQ_CHECK_EN
  logic [15:0] eseq_a, eseq_b;
  logic [3:0]  eseq_c;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int t[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  packet_sink u_a (
    .clk(clk), .a_rst(rst_n), .data_i(din), .wr_ready_in(wr),
    .r_ready_out(rdy_a), .pack_cnt(pack_a), .flit_cnt(flit_a),
    .err_addr_cnt(eaddr_a), .err_len_cnt(elen_a), .last_len(llen_a),
    .busy(busy_a)
`ifdef PACKET_SINK_SEQ_CHECK_EN
    , .err_seq_cnt(eseq_a)
`endif
  );

  packet_sink #(.DRAIN_PERIOD(4)) u_b (
    .clk(clk), .a_rst(rst_n), .data_i(din), .wr_ready_in(wr),
    .r_ready_out(rdy_b), .pack_cnt(pack_b), .flit_cnt(flit_b),
    .err_addr_cnt(eaddr_b), .err_len_cnt(elen_b), .last_len(llen_b),
    .busy(busy_b)
`ifdef PACKET_SINK_SEQ_CHECK_EN
    , .err_seq_cnt(eseq_b)
`endif
  );

  packet_sink #(.CNT_W(4)) u_c (
    .clk(clk), .a_rst(rst_n), .data_i(din), .wr_ready_in(wr),
    .r_ready_out(rdy_c), .pack_cnt(pack_c), .flit_cnt(flit_c),
    .err_addr_cnt(eaddr_c), .err_len_cnt(elen_c), .last_len(llen_c),
    .busy(busy_c)
`ifdef PACKET_SINK_SEQ_CHECK_EN
    , .err_seq_cnt(eseq_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] flit(input logic last, input logic [3:0] a, input logic [7:0] d);
    return {last, a, d};
  endfunction

  function automatic logic sel_rdy(input int sel);
    case (sel)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  // Present a flit and hold it until the selected instance accepts it.
  // Ready is registered, so its value at a negedge holds through the next posedge.
  task automatic send(input int sel, input logic [12:0] f);
    bit ok = 1'b0;
    din = f;
    wr  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel_rdy(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end else begin
      chk("send_timeout", 32'(0), 32'(1));
    end
    wr = 1'b0;
  endtask

  task automatic do_reset();
    wr    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    din   = '0;
    wr    = 1'b0;
    rst_n = 1'b0;

    // 1: reset values, then a single-flit packet
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy",   32'(rdy_a),   32'(0));
    chk("rst_pack",  32'(pack_a),  32'(0));
    chk("rst_flit",  32'(flit_a),  32'(0));
    chk("rst_eaddr", 32'(eaddr_a), 32'(0));
    chk("rst_elen",  32'(elen_a),  32'(0));
    chk("rst_llen",  32'(llen_a),  32'(0));
    chk("rst_busy",  32'(busy_a),  32'(0));
    rst_n = 1'b1;
    send(0, flit(1'b1, 4'h0, 8'h5A));
    chk("t1_busy_acc", 32'(busy_a), 32'(1));
    chk("t1_pack_acc", 32'(pack_a), 32'(0));
    @(posedge clk);
    @(negedge clk);
    chk("t1_pack",  32'(pack_a),  32'(1));
    chk("t1_flit",  32'(flit_a),  32'(1));
    chk("t1_llen",  32'(llen_a),  32'(1));
    chk("t1_eaddr", 32'(eaddr_a), 32'(0));
    chk("t1_elen",  32'(elen_a),  32'(0));
    chk("t1_busy",  32'(busy_a),  32'(0));
    chk("t1_rdy",   32'(rdy_a),   32'(1));

    // 2: four back-to-back flits with data 1..4
    do_reset();
    for (int i = 1; i <= 4; i++)
      send(0, flit(i == 4, 4'h0, 8'(i)));
    idle(4);
    chk("t2_pack", 32'(pack_a), 32'(1));
    chk("t2_flit", 32'(flit_a), 32'(4));
    chk("t2_llen", 32'(llen_a), 32'(4));
    chk("t2_busy", 32'(busy_a), 32'(0));
`ifdef PACKET_SINK_SEQ_CHECK_EN
    chk("t2_eseq", 32'(eseq_a), 32'(0));
`endif

    // 3: DRAIN_PERIOD=4 throttles an 8-flit packet
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(1, flit(i == 7, 4'h0, 8'(i + 1)));
      t[i] = acc_cyc;
      if (i == 3) chk("t3_rdy_full", 32'(rdy_b), 32'(0));
    end
    chk("t3_gap_5", 32'(t[5] - t[4]), 32'(4));
    chk("t3_gap_6", 32'(t[6] - t[5]), 32'(4));
    chk("t3_gap_7", 32'(t[7] - t[6]), 32'(4));
    idle(40);
    chk("t3_flit",  32'(flit_b),  32'(8));
    chk("t3_pack",  32'(pack_b),  32'(1));
    chk("t3_llen",  32'(llen_b),  32'(8));
    chk("t3_rdy",   32'(rdy_b),   32'(1));
    chk("t3_busy",  32'(busy_b),  32'(0));
    chk("t3_eaddr", 32'(eaddr_b), 32'(0));
    chk("t3_elen",  32'(elen_b),  32'(0));
`ifdef PACKET_SINK_SEQ_CHECK_EN
    chk("t3_eseq", 32'(eseq_b), 32'(0));
`endif

    // 4: bad address in a 3-flit packet, then a 10-flit over-length packet
    do_reset();
    send(0, flit(1'b0, 4'h0, 8'h10));
    send(0, flit(1'b0, 4'h1, 8'h11));
    send(0, flit(1'b1, 4'h0, 8'h12));
    for (int i = 0; i < 10; i++)
      send(0, flit(i == 9, 4'h0, 8'(8'h20 + i)));
    idle(4);
    chk("t4_eaddr", 32'(eaddr_a), 32'(1));
    chk("t4_elen",  32'(elen_a),  32'(1));
    chk("t4_pack",  32'(pack_a),  32'(2));
    chk("t4_llen",  32'(llen_a),  32'(10));
    chk("t4_flit",  32'(flit_a),  32'(13));
`ifdef PACKET_SINK_SEQ_CHECK_EN
    chk("t4_eseq", 32'(eseq_a), 32'(0));
    send(0, flit(1'b0, 4'h0, 8'h01));
    send(0, flit(1'b1, 4'h0, 8'h05));
    idle(4);
    chk("t4_eseq_bad", 32'(eseq_a), 32'(1));
`endif

    // 5: asynchronous reset with two flits buffered in u_b
    do_reset();
    send(1, flit(1'b0, 4'h0, 8'h01));
    send(1, flit(1'b0, 4'h0, 8'h02));
    chk("t5_busy_pre", 32'(busy_b), 32'(1));
    chk("t5_flit_pre", 32'(flit_b), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy",  32'(rdy_b),  32'(0));
    chk("t5_rst_busy", 32'(busy_b), 32'(0));
    chk("t5_rst_pack", 32'(pack_b), 32'(0));
    chk("t5_rst_flit", 32'(flit_b), 32'(0));
    chk("t5_rst_llen", 32'(llen_b), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(1, flit(1'b0, 4'h0, 8'h07));
    send(1, flit(1'b1, 4'h0, 8'h08));
    idle(20);
    chk("t5_pack",  32'(pack_b),  32'(1));
    chk("t5_flit",  32'(flit_b),  32'(2));
    chk("t5_llen",  32'(llen_b),  32'(2));
    chk("t5_eaddr", 32'(eaddr_b), 32'(0));

    // 6: 4-bit counters saturate after 17 single-flit packets
    do_reset();
    for (int i = 0; i < 17; i++)
      send(2, flit(1'b1, 4'h0, 8'(i)));
    idle(4);
    chk("t6_pack",  32'(pack_c),  32'(4'hF));
    chk("t6_flit",  32'(flit_c),  32'(4'hF));
    chk("t6_eaddr", 32'(eaddr_c), 32'(0));
    chk("t6_elen",  32'(elen_c),  32'(0));
    chk("t6_llen",  32'(llen_c),  32'(1));
    chk("t6_busy",  32'(busy_c),  32'(0));
    chk("t6_rdy",   32'(rdy_c),   32'(1));
`ifdef PACKET_SINK_SEQ_CHECK_EN
    chk("t6_eseq", 32'(eseq_c), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
